// File: rtl/memory_game_ctrl.sv
// Turn and score controller for the card-matching memory game: validates flips,
// compares pairs, tracks removed positions, rotates players and reports the winner.
module memory_game_ctrl #(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned NUM_PAIRS      = 4,
    parameter int unsigned SCORE_W        = $clog2(NUM_PAIRS + 1),
    parameter int unsigned TIMEOUT_CYCLES = 0,
    localparam int unsigned PW            = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int unsigned NUM_CARDS     = 2 * NUM_PAIRS,
    localparam int unsigned POS_W         = $clog2(NUM_CARDS),
    localparam int unsigned CARD_W        = (NUM_PAIRS > 2) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic                           flip_valid_i,
    input  logic [POS_W-1:0]               flip_pos_i,
    input  logic [CARD_W-1:0]              flip_card_i,
    output logic                           flip_ready_o,
    output logic [PW-1:0]                  player_o,
    output logic                           match_o,
    output logic                           mismatch_o,
    output logic                           illegal_o,
    output logic                           timeout_o,
    output logic [NUM_CARDS-1:0]           removed_o,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
    output logic                           game_over_o,
    output logic [PW-1:0]                  winner_o,
    output logic                           tie_o
);

    localparam int unsigned PAIR_W  = $clog2(NUM_PAIRS + 1);
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                                state_q, state_d;
    logic [PW-1:0]                         player_q, player_d;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   scores_q, scores_d;
    logic [NUM_CARDS-1:0]                  removed_q, removed_d;
    logic [PAIR_W-1:0]                     pairs_q, pairs_d;
    logic [POS_W-1:0]                      first_pos_q, first_pos_d;
    logic [CARD_W-1:0]                     first_card_q, first_card_d;
    logic [TO_W-1:0]                       cnt_q, cnt_d;
    logic                                  match_q, match_d;
    logic                                  mismatch_q, mismatch_d;
    logic                                  illegal_q, illegal_d;
    logic                                  timeout_q, timeout_d;
    logic                                  flip_ready_q, flip_ready_d;
    logic                                  game_over_q, game_over_d;
    logic [PW-1:0]                         winner_q, winner_d;
    logic                                  tie_q, tie_d;

    logic                                  in_turn;
    logic                                  expire;
    logic                                  pos_oob;
    logic                                  pos_removed;
    logic [SCORE_W-1:0]                    best_score;
    logic [PW-1:0]                         best_idx;
    logic [PW:0]                           best_cnt;

    function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
        return (p == PW'(NUM_PLAYERS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Positions beyond the board behave as already removed.
    assign pos_oob     = ({1'b0, flip_pos_i} >= (POS_W + 1)'(NUM_CARDS));
    assign pos_removed = pos_oob || removed_q[flip_pos_i];
    assign in_turn     = (state_q == S_FIRST) || (state_q == S_SECOND);
    // A flip in the expiry cycle takes precedence over the timeout.
    assign expire      = (TIMEOUT_CYCLES != 0) && in_turn && !flip_valid_i
                         && (cnt_q == TO_W'(TO_LAST));

    always_comb begin
        state_d      = state_q;
        player_d     = player_q;
        scores_d     = scores_q;
        removed_d    = removed_q;
        pairs_d      = pairs_q;
        first_pos_d  = first_pos_q;
        first_card_d = first_card_q;
        cnt_d        = '0;
        match_d      = 1'b0;
        mismatch_d   = 1'b0;
        illegal_d    = 1'b0;
        timeout_d    = 1'b0;
        best_score   = '0;
        best_idx     = '0;
        best_cnt     = '0;

        if (in_turn && !flip_valid_i && !expire) begin
            cnt_d = cnt_q + TO_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    player_d  = '0;
                    scores_d  = '0;
                    removed_d = '0;
                    pairs_d   = PAIR_W'(NUM_PAIRS);
                    state_d   = S_FIRST;
                end
            end
            S_FIRST: begin
                if (flip_valid_i) begin
                    if (pos_removed) begin
                        illegal_d = 1'b1;
                    end else begin
                        first_pos_d  = flip_pos_i;
                        first_card_d = flip_card_i;
                        state_d      = S_SECOND;
                    end
                end else if (expire) begin
                    timeout_d = 1'b1;
                    player_d  = next_player(player_q);
                end
            end
            S_SECOND: begin
                if (flip_valid_i) begin
                    if (pos_removed || (flip_pos_i == first_pos_q)) begin
                        illegal_d = 1'b1;
                    end else if (flip_card_i == first_card_q) begin
                        match_d                = 1'b1;
                        removed_d[flip_pos_i]  = 1'b1;
                        removed_d[first_pos_q] = 1'b1;
                        scores_d[player_q]     = scores_q[player_q] + SCORE_W'(1);
                        pairs_d                = pairs_q - PAIR_W'(1);
                        state_d = (pairs_q == PAIR_W'(1)) ? S_DONE : S_FIRST;
                    end else begin
                        mismatch_d = 1'b1;
                        player_d   = next_player(player_q);
                        state_d    = S_FIRST;
                    end
                end else if (expire) begin
                    timeout_d = 1'b1;
                    player_d  = next_player(player_q);
                    state_d   = S_FIRST;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Lowest-index player holding the maximum score; count holders for tie.
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (scores_d[i] > best_score) begin
                best_score = scores_d[i];
                best_idx   = PW'(i);
                best_cnt   = (PW + 1)'(1);
            end else if (scores_d[i] == best_score) begin
                best_cnt = best_cnt + (PW + 1)'(1);
            end
        end

        winner_d     = best_idx;
        tie_d        = (best_cnt > (PW + 1)'(1));
        flip_ready_d = (state_d == S_FIRST) || (state_d == S_SECOND);
        game_over_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            player_q     <= '0;
            scores_q     <= '0;
            removed_q    <= '0;
            pairs_q      <= PAIR_W'(NUM_PAIRS);
            first_pos_q  <= '0;
            first_card_q <= '0;
            cnt_q        <= '0;
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            flip_ready_q <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= '0;
            tie_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            player_q     <= player_d;
            scores_q     <= scores_d;
            removed_q    <= removed_d;
            pairs_q      <= pairs_d;
            first_pos_q  <= first_pos_d;
            first_card_q <= first_card_d;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            mismatch_q   <= mismatch_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            flip_ready_q <= flip_ready_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            tie_q        <= tie_d;
        end
    end

    assign flip_ready_o = flip_ready_q;
    assign player_o     = player_q;
    assign match_o      = match_q;
    assign mismatch_o   = mismatch_q;
    assign illegal_o    = illegal_q;
    assign timeout_o    = timeout_q;
    assign removed_o    = removed_q;
    assign scores_o     = scores_q;
    assign game_over_o  = game_over_q;
    assign winner_o     = winner_q;
    assign tie_o        = tie_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: directed game scenarios plus randomized play,
// every cycle compared against a rule-level game model.
module tb_memory_game_ctrl;

    localparam int NP = 3;
    localparam int NPAIRS = 2;
    localparam int NC = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       fv;
    logic [1:0] fp;
    logic [0:0] fc;
    logic       flip_ready;
    logic [1:0] player;
    logic       match;
    logic       mismatch;
    logic       illegal;
    logic       timeout;
    logic [3:0] removed;
    logic [5:0] scores;
    logic       game_over;
    logic [1:0] winner;
    logic       tie;

    memory_game_ctrl #(
        .NUM_PLAYERS    (NP),
        .NUM_PAIRS      (NPAIRS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .flip_valid_i (fv),
        .flip_pos_i   (fp),
        .flip_card_i  (fc),
        .flip_ready_o (flip_ready),
        .player_o     (player),
        .match_o      (match),
        .mismatch_o   (mismatch),
        .illegal_o    (illegal),
        .timeout_o    (timeout),
        .removed_o    (removed),
        .scores_o     (scores),
        .game_over_o  (game_over),
        .winner_o     (winner),
        .tie_o        (tie)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Game model: phase 0=idle, 1=waiting first card, 2=waiting second card, 3=game over
    int m_phase;
    int m_player;
    int m_score[NP];
    bit m_removed[NC];
    int m_left;
    int m_fpos;
    int m_fcard;
    int m_idle;
    bit m_match, m_mismatch, m_illegal, m_timeout;
    int deck[NC];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_new_game();
        m_player = 0;
        m_left   = NPAIRS;
        m_idle   = 0;
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        for (int i = 0; i < NC; i++) m_removed[i] = 1'b0;
    endfunction

    function automatic void model_reset();
        model_new_game();
        m_phase = 0;
        m_fpos = 0;
        m_fcard = 0;
        m_match = 0; m_mismatch = 0; m_illegal = 0; m_timeout = 0;
    endfunction

    function automatic void model_step(input bit s, input bit v, input int p, input int c);
        bit gone;
        m_match = 0; m_mismatch = 0; m_illegal = 0; m_timeout = 0;
        gone = (p >= NC) ? 1'b1 : m_removed[p];
        if (m_phase == 0 || m_phase == 3) begin
            if (s) begin
                model_new_game();
                m_phase = 1;
            end
        end else if (v) begin
            m_idle = 0;
            if (m_phase == 1) begin
                if (gone) m_illegal = 1;
                else begin
                    m_fpos = p; m_fcard = c; m_phase = 2;
                end
            end else begin
                if (gone || p == m_fpos) m_illegal = 1;
                else if (c == m_fcard) begin
                    m_match = 1;
                    m_removed[p] = 1'b1;
                    m_removed[m_fpos] = 1'b1;
                    m_score[m_player]++;
                    m_left--;
                    m_phase = (m_left == 0) ? 3 : 1;
                end else begin
                    m_mismatch = 1;
                    m_player = (m_player + 1) % NP;
                    m_phase = 1;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_timeout = 1;
                m_player = (m_player + 1) % NP;
                m_phase = 1;
                m_idle = 0;
            end
        end
    endfunction

    function automatic logic [5:0] exp_scores();
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*2 +: 2] = 2'(m_score[i]);
        return r;
    endfunction

    function automatic logic [3:0] exp_removed();
        logic [3:0] r;
        for (int i = 0; i < NC; i++) r[i] = m_removed[i];
        return r;
    endfunction

    task automatic check_all();
        int best, w, cnt;
        best = -1; w = 0; cnt = 0;
        for (int i = 0; i < NP; i++) begin
            if (m_score[i] > best) begin
                best = m_score[i]; w = i; cnt = 1;
            end else if (m_score[i] == best) cnt++;
        end
        check_eq("flip_ready", 32'(flip_ready), 32'(m_phase == 1 || m_phase == 2));
        check_eq("game_over", 32'(game_over), 32'(m_phase == 3));
        check_eq("player", 32'(player), 32'(m_player));
        check_eq("match", 32'(match), 32'(m_match));
        check_eq("mismatch", 32'(mismatch), 32'(m_mismatch));
        check_eq("illegal", 32'(illegal), 32'(m_illegal));
        check_eq("timeout", 32'(timeout), 32'(m_timeout));
        check_eq("scores", 32'(scores), 32'(exp_scores()));
        check_eq("removed", 32'(removed), 32'(exp_removed()));
        if (m_phase == 3) begin
            check_eq("winner", 32'(winner), 32'(w));
            check_eq("tie", 32'(tie), 32'(cnt > 1));
        end
    endtask

    task automatic tick(input bit s, input bit v, input int p, input int c);
        start = s; fv = v; fp = 2'(p); fc = 1'(c);
        @(posedge clk);
        model_step(s, v, p, c);
        #1;
        check_all();
        start = 1'b0; fv = 1'b0;
    endtask

    task automatic flip(input int p, input int c);
        tick(1'b0, 1'b1, p, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic shuffle_deck();
        int j, t;
        deck[0] = 0; deck[1] = 0; deck[2] = 1; deck[3] = 1;
        for (int i = NC - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = deck[i]; deck[i] = deck[j]; deck[j] = t;
        end
    endtask

    initial begin
        int prob, p, c;
        bit s;
        rst = 1'b1; start = 1'b0; fv = 1'b0; fp = '0; fc = '0;
        model_reset();
        #12;
        check_all();
        check_eq("rst_all_zero", 32'({flip_ready, game_over, match, mismatch, illegal, timeout,
                                      player, scores, removed}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Match by player 0
        tick(1'b1, 1'b0, 0, 0);
        flip(0, 1);
        flip(1, 1);
        check_eq("first_match_scores", 32'(scores), 32'h01);
        check_eq("first_match_removed", 32'(removed), 32'h3);
        check_eq("first_match_pulse", 32'(match), 32'h1);

        // Mismatches rotate 0->1->2->0
        flip(2, 0); flip(3, 1);
        flip(2, 0); flip(3, 1);
        check_eq("player_is_2", 32'(player), 32'h2);
        flip(2, 0); flip(3, 1);
        check_eq("player_wraps", 32'(player), 32'h0);
        check_eq("mismatch_pulse", 32'(mismatch), 32'h1);

        // Illegal flips
        flip(0, 1);
        check_eq("illegal_removed", 32'(illegal), 32'h1);
        flip(2, 0);
        flip(2, 0);
        check_eq("illegal_same_pos", 32'(illegal), 32'h1);
        check_eq("still_second_ready", 32'(flip_ready), 32'h1);

        // Timeout in SECOND
        idle(7);
        check_eq("no_timeout_yet", 32'(timeout), 32'h0);
        idle(1);
        check_eq("timeout_pulse", 32'(timeout), 32'h1);
        check_eq("timeout_player", 32'(player), 32'h1);

        // Flip on the eighth idle cycle wins over timeout
        flip(2, 0);
        idle(7);
        flip(3, 1);
        check_eq("late_flip_no_timeout", 32'(timeout), 32'h0);
        check_eq("late_flip_mismatch", 32'(mismatch), 32'h1);
        check_eq("late_flip_player", 32'(player), 32'h2);

        // Timeout in FIRST hands turn to player 0, who completes the board
        idle(8);
        check_eq("first_timeout_player", 32'(player), 32'h0);
        flip(2, 0);
        flip(3, 0);
        check_eq("done_game_over", 32'(game_over), 32'h1);
        check_eq("done_ready_low", 32'(flip_ready), 32'h0);
        check_eq("done_scores", 32'(scores), 32'h02);
        check_eq("done_winner", 32'(winner), 32'h0);
        check_eq("done_tie", 32'(tie), 32'h0);
        flip(0, 1);
        tick(1'b1, 1'b0, 0, 0);
        check_eq("restart_scores", 32'(scores), 32'h0);
        check_eq("restart_ready", 32'(flip_ready), 32'h1);

        // Tie between players 0 and 1
        flip(0, 1); flip(1, 1);
        flip(2, 0); flip(3, 1);
        flip(2, 0); flip(3, 0);
        check_eq("tie_scores", 32'(scores), 32'h05);
        check_eq("tie_flag", 32'(tie), 32'h1);
        check_eq("tie_winner", 32'(winner), 32'h0);

        // Reset in the middle of SECOND
        tick(1'b1, 1'b0, 0, 0);
        flip(0, 1);
        async_reset();
        check_eq("midturn_rst", 32'({flip_ready, game_over, match, mismatch, illegal, timeout,
                                     player, scores, removed}), 32'h0);

        // Randomized play
        shuffle_deck();
        for (int seg = 0; seg < 12; seg++) begin
            case (seg % 3)
                0: prob = 90;
                1: prob = 40;
                default: prob = 12;
            endcase
            for (int cyc = 0; cyc < 200; cyc++) begin
                if ($urandom_range(0, 999) < 3) begin
                    async_reset();
                end else begin
                    s = ($urandom_range(0, 99) < 5);
                    if (s && (m_phase == 0 || m_phase == 3)) shuffle_deck();
                    p = $urandom_range(0, NC - 1);
                    c = ($urandom_range(0, 99) < 85) ? deck[p] : $urandom_range(0, 1);
                    tick(s, ($urandom_range(0, 99) < prob), p, c);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
